// File: rtl/riscv_pkg.sv
// Shared RV32I multi-cycle control definitions: opcodes, datapath select encodings, states, classes.
// Pure declarations; no logic, no latency, no flow control.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_ALU   = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  localparam logic [1:0] ALU_ADD  = 2'd0;
  localparam logic [1:0] ALU_FUNC = 2'd1;
  localparam logic [1:0] ALU_BR   = 2'd2;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  // CL_NONE doubles as the reset value of the class register and the illegal marker.
  typedef enum logic [3:0] {
    CL_NONE   = 4'd0,
    CL_R      = 4'd1,
    CL_IMM    = 4'd2,
    CL_LOAD   = 4'd3,
    CL_STORE  = 4'd4,
    CL_BRANCH = 4'd5,
    CL_JAL    = 4'd6,
    CL_JALR   = 4'd7,
    CL_LUI    = 4'd8,
    CL_AUIPC  = 4'd9
  } class_e;

endpackage

// File: rtl/riscv_opclass.sv
// Combinational opcode -> instruction class mapper with illegal-opcode flag.
// Zero latency; no handshake.
module riscv_opclass
  import riscv_pkg::*;
(
  input  logic [6:0] opcode,
  output class_e     cls,
  output logic       illegal
);

  always_comb begin
    cls = CL_NONE;
    case (opcode)
      OP_R:      cls = CL_R;
      OP_IMM:    cls = CL_IMM;
      OP_LOAD:   cls = CL_LOAD;
      OP_STORE:  cls = CL_STORE;
      OP_BRANCH: cls = CL_BRANCH;
      OP_JAL:    cls = CL_JAL;
      OP_JALR:   cls = CL_JALR;
      OP_LUI:    cls = CL_LUI;
      OP_AUIPC:  cls = CL_AUIPC;
      default:   cls = CL_NONE;
    endcase
    illegal = (cls == CL_NONE);
  end

endmodule

// File: rtl/riscv_mc_control.sv
// Multi-cycle RV32I sequencer FETCH/DECODE/EXEC/MEM/WB with trap state and retire counter.
// CPI 3-5 at zero wait; FETCH and MEM hold requests and selects until imem_ack/dmem_ack.
module riscv_mc_control
  import riscv_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             branch_taken,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic             alu_a_sel,
  output logic             alu_b_sel,
  output logic [1:0]       alu_op,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  state_e           state_q, state_d;
  class_e           cls_q, cls_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  class_e           dec_cls;
  logic             dec_illegal;

  riscv_opclass u_opclass (
    .opcode  (opcode),
    .cls     (dec_cls),
    .illegal (dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      cls_q     <= CL_NONE;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = PC_PLUS4;
    rf_we     = 1'b0;
    wb_sel    = WB_ALU;
    alu_a_sel = 1'b0;
    alu_b_sel = 1'b0;
    alu_op    = ALU_ADD;
    illegal   = 1'b0;

    // ALU selects stay put from EXEC through MEM/WB so address and jump target are stable.
    if (state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB) begin
      case (cls_q)
        CL_R:      alu_op = ALU_FUNC;
        CL_IMM: begin
          alu_op    = ALU_FUNC;
          alu_b_sel = 1'b1;
        end
        CL_LOAD, CL_STORE, CL_JALR: alu_b_sel = 1'b1;
        CL_AUIPC: begin
          alu_a_sel = 1'b1;
          alu_b_sel = 1'b1;
        end
        CL_BRANCH: alu_op = ALU_BR;
        default: ;
      endcase
    end

    case (state_q)
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we   = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        cls_d   = dec_cls;
        state_d = dec_illegal ? ST_TRAP : ST_EXEC;
      end
      ST_EXEC: begin
        if (cls_q == CL_BRANCH) begin
          pc_we   = 1'b1;
          pc_sel  = branch_taken ? PC_IMM : PC_PLUS4;
          state_d = ST_FETCH;
        end else if (cls_q == CL_LOAD || cls_q == CL_STORE) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls_q == CL_STORE);
        if (dmem_ack) begin
          if (cls_q == CL_STORE) begin
            pc_we   = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end
      end
      ST_WB: begin
        rf_we   = 1'b1;
        pc_we   = 1'b1;
        state_d = ST_FETCH;
        case (cls_q)
          CL_LOAD:         wb_sel = WB_MEM;
          CL_JAL, CL_JALR: wb_sel = WB_PC4;
          CL_LUI:          wb_sel = WB_IMM;
          default:         wb_sel = WB_ALU;
        endcase
        case (cls_q)
          CL_JAL:  pc_sel = PC_IMM;
          CL_JALR: pc_sel = PC_ALU;
          default: pc_sel = PC_PLUS4;
        endcase
      end
      ST_TRAP: illegal = 1'b1;
      default: state_d = ST_FETCH;
    endcase

    // Reset silences every output in the same cycle, regardless of the current state.
    if (rst) begin
      imem_req  = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      pc_sel    = PC_PLUS4;
      rf_we     = 1'b0;
      wb_sel    = WB_ALU;
      alu_a_sel = 1'b0;
      alu_b_sel = 1'b0;
      alu_op    = ALU_ADD;
      illegal   = 1'b0;
    end

    instret_d = instret_q + {{(CNT_W-1){1'b0}}, pc_we};
    instret   = rst ? '0 : instret_q;
  end

endmodule

// File: tb/tb_riscv_mc_control.sv
// Per-cycle vector table for riscv_mc_control; expected outputs queued at drive time, popped at sample.
// Covers reset, every instruction class, memory wait states, mid-operation reset and the trap state.
module tb_riscv_mc_control;

  typedef struct packed {
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       rf_we;
    logic [1:0] wb_sel;
    logic       alu_a_sel;
    logic       alu_b_sel;
    logic [1:0] alu_op;
    logic       illegal;
  } out_t;

  typedef struct {
    logic        rst;
    logic [6:0]  opc;
    logic        bt;
    logic        ia;
    logic        da;
    out_t        exp;
    int unsigned ir;
  } vec_t;

  typedef struct {
    out_t        exp;
    int unsigned ir;
    int          idx;
  } sb_t;

  localparam logic [6:0] O_R   = 7'b0110011;
  localparam logic [6:0] O_IMM = 7'b0010011;
  localparam logic [6:0] O_LD  = 7'b0000011;
  localparam logic [6:0] O_ST  = 7'b0100011;
  localparam logic [6:0] O_BR  = 7'b1100011;
  localparam logic [6:0] O_JAL = 7'b1101111;
  localparam logic [6:0] O_JR  = 7'b1100111;
  localparam logic [6:0] O_LUI = 7'b0110111;
  localparam logic [6:0] O_AUI = 7'b0010111;
  localparam logic [6:0] O_BAD = 7'h7F;

  logic        clk;
  logic        rst;
  logic [6:0]  opcode;
  logic        branch_taken;
  logic        imem_ack;
  logic        dmem_ack;
  logic        imem_req;
  logic        dmem_req;
  logic        dmem_we;
  logic        ir_we;
  logic        pc_we;
  logic [1:0]  pc_sel;
  logic        rf_we;
  logic [1:0]  wb_sel;
  logic        alu_a_sel;
  logic        alu_b_sel;
  logic [1:0]  alu_op;
  logic        illegal;
  logic [31:0] instret;

  riscv_mc_control #(.CNT_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .opcode       (opcode),
    .branch_taken (branch_taken),
    .imem_ack     (imem_ack),
    .dmem_ack     (dmem_ack),
    .imem_req     (imem_req),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .rf_we        (rf_we),
    .wb_sel       (wb_sel),
    .alu_a_sel    (alu_a_sel),
    .alu_b_sel    (alu_b_sel),
    .alu_op       (alu_op),
    .illegal      (illegal),
    .instret      (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vec_t vecs[$];
  sb_t  sbq[$];
  int   checks;
  int   errors;

  function automatic out_t o_fetch(input logic ack);
    out_t e = '0;
    e.imem_req = 1'b1;
    e.ir_we    = ack;
    return e;
  endfunction

  function automatic out_t o_ex(input logic a, input logic b, input logic [1:0] op);
    out_t e = '0;
    e.alu_a_sel = a;
    e.alu_b_sel = b;
    e.alu_op    = op;
    return e;
  endfunction

  function automatic out_t o_br(input logic taken);
    out_t e = o_ex(1'b0, 1'b0, 2'd2);
    e.pc_we  = 1'b1;
    e.pc_sel = taken ? 2'd1 : 2'd0;
    return e;
  endfunction

  function automatic out_t o_mem(input logic st, input logic ack);
    out_t e = o_ex(1'b0, 1'b1, 2'd0);
    e.dmem_req = 1'b1;
    e.dmem_we  = st;
    e.pc_we    = st & ack;
    return e;
  endfunction

  function automatic out_t o_wb(input logic [1:0] wbs, input logic [1:0] pcs,
                                input logic a, input logic b, input logic [1:0] op);
    out_t e = o_ex(a, b, op);
    e.rf_we  = 1'b1;
    e.pc_we  = 1'b1;
    e.wb_sel = wbs;
    e.pc_sel = pcs;
    return e;
  endfunction

  function automatic out_t o_trap();
    out_t e = '0;
    e.illegal = 1'b1;
    return e;
  endfunction

  task automatic add(input logic r, input logic [6:0] op, input logic bt, input logic ia,
                     input logic da, input out_t e, input int unsigned ir);
    vec_t v;
    v.rst = r; v.opc = op; v.bt = bt; v.ia = ia; v.da = da; v.exp = e; v.ir = ir;
    vecs.push_back(v);
  endtask

  task automatic build_table();
    for (int i = 0; i < 3; i++) add(1, 7'h00, 0, 1, 1, '0, 0);
    // R-type add, zero-wait: first post-reset cycle both requests and acks
    add(0, O_R, 0, 1, 0, o_fetch(1), 0);
    add(0, O_R, 0, 0, 0, '0, 0);
    add(0, O_R, 0, 0, 0, o_ex(0, 0, 1), 0);
    add(0, O_R, 0, 0, 0, o_wb(0, 0, 0, 0, 1), 0);
    // LOAD with three data wait cycles
    add(0, O_LD, 0, 1, 0, o_fetch(1), 1);
    add(0, O_LD, 0, 0, 0, '0, 1);
    add(0, O_LD, 0, 0, 0, o_ex(0, 1, 0), 1);
    for (int i = 0; i < 3; i++) add(0, O_LD, 0, 0, 0, o_mem(0, 0), 1);
    add(0, O_LD, 0, 0, 1, o_mem(0, 1), 1);
    add(0, O_LD, 0, 0, 0, o_wb(1, 0, 0, 1, 0), 1);
    // BRANCH taken, then not taken with branch_taken high only during DECODE
    add(0, O_BR, 0, 1, 0, o_fetch(1), 2);
    add(0, O_BR, 0, 0, 0, '0, 2);
    add(0, O_BR, 1, 0, 0, o_br(1), 2);
    add(0, O_BR, 0, 1, 0, o_fetch(1), 3);
    add(0, O_BR, 1, 0, 0, '0, 3);
    add(0, O_BR, 0, 0, 0, o_br(0), 3);
    // JALR with two fetch wait cycles
    add(0, O_JR, 0, 0, 0, o_fetch(0), 4);
    add(0, O_JR, 0, 0, 0, o_fetch(0), 4);
    add(0, O_JR, 0, 1, 0, o_fetch(1), 4);
    add(0, O_JR, 0, 0, 0, '0, 4);
    add(0, O_JR, 0, 0, 0, o_ex(0, 1, 0), 4);
    add(0, O_JR, 0, 0, 0, o_wb(2, 2, 0, 1, 0), 4);
    // LUI
    add(0, O_LUI, 0, 1, 0, o_fetch(1), 5);
    add(0, O_LUI, 0, 0, 0, '0, 5);
    add(0, O_LUI, 0, 0, 0, o_ex(0, 0, 0), 5);
    add(0, O_LUI, 0, 0, 0, o_wb(3, 0, 0, 0, 0), 5);
    // STORE, stray dmem_ack in EXEC must not short-circuit MEM
    add(0, O_ST, 0, 1, 0, o_fetch(1), 6);
    add(0, O_ST, 0, 0, 0, '0, 6);
    add(0, O_ST, 0, 0, 1, o_ex(0, 1, 0), 6);
    add(0, O_ST, 0, 0, 1, o_mem(1, 1), 6);
    // AUIPC, JAL, I-ALU
    add(0, O_AUI, 0, 1, 0, o_fetch(1), 7);
    add(0, O_AUI, 0, 0, 0, '0, 7);
    add(0, O_AUI, 0, 0, 0, o_ex(1, 1, 0), 7);
    add(0, O_AUI, 0, 0, 0, o_wb(0, 0, 1, 1, 0), 7);
    add(0, O_JAL, 0, 1, 0, o_fetch(1), 8);
    add(0, O_JAL, 0, 0, 0, '0, 8);
    add(0, O_JAL, 0, 0, 0, o_ex(0, 0, 0), 8);
    add(0, O_JAL, 0, 0, 0, o_wb(2, 1, 0, 0, 0), 8);
    add(0, O_IMM, 0, 1, 0, o_fetch(1), 9);
    add(0, O_IMM, 0, 0, 0, '0, 9);
    add(0, O_IMM, 0, 0, 0, o_ex(0, 1, 1), 9);
    add(0, O_IMM, 0, 0, 0, o_wb(0, 0, 0, 1, 1), 9);
    // Illegal opcode: trap for 20 cycles with acks hammering, instret frozen
    add(0, O_BAD, 0, 1, 0, o_fetch(1), 10);
    add(0, O_BAD, 0, 0, 0, '0, 10);
    for (int i = 0; i < 20; i++) add(0, O_BAD, 1, 1, 1, o_trap(), 10);
    add(1, O_BAD, 0, 0, 0, '0, 0);
    add(0, O_LD, 0, 0, 0, o_fetch(0), 0);
    // Reset in the middle of a LOAD data wait; late dmem_ack afterwards is ignored
    add(0, O_LD, 0, 1, 0, o_fetch(1), 0);
    add(0, O_LD, 0, 0, 0, '0, 0);
    add(0, O_LD, 0, 0, 0, o_ex(0, 1, 0), 0);
    add(0, O_LD, 0, 0, 0, o_mem(0, 0), 0);
    add(1, O_LD, 0, 0, 1, '0, 0);
    add(0, O_LD, 0, 0, 1, o_fetch(0), 0);
    add(0, O_LD, 0, 0, 0, o_fetch(0), 0);
    // One more R-type to confirm the counter restarts from zero
    add(0, O_R, 0, 1, 0, o_fetch(1), 0);
    add(0, O_R, 0, 0, 0, '0, 0);
    add(0, O_R, 0, 0, 0, o_ex(0, 0, 1), 0);
    add(0, O_R, 0, 0, 0, o_wb(0, 0, 0, 0, 1), 0);
    add(0, O_R, 0, 0, 0, o_fetch(0), 1);
  endtask

  initial begin
    out_t act;
    sb_t  s;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    opcode = 7'h00;
    branch_taken = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    build_table();

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      rst          = vecs[i].rst;
      opcode       = vecs[i].opc;
      branch_taken = vecs[i].bt;
      imem_ack     = vecs[i].ia;
      dmem_ack     = vecs[i].da;
      sbq.push_back('{exp: vecs[i].exp, ir: vecs[i].ir, idx: i});

      @(negedge clk);
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty vec=%0d", i);
      end else begin
        s = sbq.pop_front();
        act = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, rf_we, wb_sel,
               alu_a_sel, alu_b_sel, alu_op, illegal};
        checks++;
        if (act !== s.exp) begin
          errors++;
          $display("FAIL outputs vec=%0d got=%b want=%b (ireq dreq dwe irwe pcwe pcsel rfwe wbsel a b aluop ill)",
                   s.idx, act, s.exp);
        end
        checks++;
        if (instret !== s.ir) begin
          errors++;
          $display("FAIL instret vec=%0d got=%0d want=%0d", s.idx, instret, s.ir);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
